// File: rtl/rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// rom_fetch_unit
//
// Read-side master for the program ROM. This block contains no ROM of its
// own: the ROM sits outside and reads combinationally. The block:
//   - drives the ROM address from an internal program counter (PC),
//   - captures the returned code word into an instruction register (IR),
//   - splits the IR into an instruction nibble and an operand nibble,
//   - offers the IR downstream with a valid/ready handshake.
//
// Each instruction takes two cycles: one FETCH cycle and at least one HOLD
// cycle. The ROM address comes straight from the PC register, so no input
// reaches rom_addr through logic alone. The ROM therefore sees a stable
// address for the whole FETCH cycle.
//
// Compile-time option (macro FETCH_HALT_ON_WRAP_EN):
//   undefined : the PC wraps from the last address to 0 without notice, and
//               halted is tied to 0.
//   defined   : after the word at the last address is fetched and
//               transferred, the unit parks in HALT with halted=1 and the PC
//               at 0. Only load or reset leaves HALT.
//
// Parameters
//   AW        address width (PC and rom_addr)
//   DW        code word width. Must be even, because it splits into two
//             DW/2 fields.
//   RST_ADDR  PC value after reset
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   en         in   1 = fetching allowed, 0 = stall (no new fetch starts)
//   load       in   jump request: PC <= load_addr, drops the held IR
//   load_addr  in   jump target
//   rom_data   in   code word returned by the ROM for rom_addr
//   rom_addr   out  ROM address, equal to the PC register
//   ir_valid   out  IR holds an instruction not yet transferred
//   ir_ready   in   downstream accepts the held instruction this cycle
//   instr      out  upper half of the IR
//   oprnd      out  lower half of the IR
//   ir_addr    out  address the held instruction was fetched from
//   halted     out  unit parked after address wrap (0 when option is off)
// ---------------------------------------------------------------------------
module rom_fetch_unit #(
  parameter int              AW       = 12,
  parameter int              DW       = 8,
  parameter logic [AW-1:0]   RST_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              load,
  input  logic [AW-1:0]     load_addr,
  input  logic [DW-1:0]     rom_data,
  output logic [AW-1:0]     rom_addr,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DW/2-1:0]   instr,
  output logic [DW/2-1:0]   oprnd,
  output logic [AW-1:0]     ir_addr,
  output logic              halted
);

  // Highest address. Fetching from here wraps the PC back to zero.
  localparam logic [AW-1:0] LAST_ADDR = '1;

`ifdef FETCH_HALT_ON_WRAP_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;
`endif

  state_t          state;
  logic [AW-1:0]   pc;
  logic [DW-1:0]   ir;
  logic [AW-1:0]   ir_addr_q;
  logic            ir_valid_q;

`ifdef FETCH_HALT_ON_WRAP_EN
  // wrap_q marks that the held instruction came from LAST_ADDR. When that
  // instruction is transferred, the unit goes to HALT instead of fetching.
  logic            wrap_q;
  logic            halted_q;
`endif

  // -------------------------------------------------------------------------
  // Control FSM and datapath registers in one clocked process. Every output
  // is taken from a register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only. Each
      // register then sees the pre-edge value of every other register, which
      // is what lets PC, IR and ir_addr all update in the same edge.
      state      <= S_IDLE;
      pc         <= RST_ADDR;
      ir         <= '0;
      ir_addr_q  <= '0;
      ir_valid_q <= 1'b0;
`ifdef FETCH_HALT_ON_WRAP_EN
      wrap_q     <= 1'b0;
      halted_q   <= 1'b0;
`endif
    end else if (load) begin
      // A jump beats any handshake on the same edge. The held word is
      // discarded even if ir_ready is high, so downstream never sees it.
      pc         <= load_addr;
      ir_valid_q <= 1'b0;
      state      <= en ? S_FETCH : S_IDLE;
`ifdef FETCH_HALT_ON_WRAP_EN
      wrap_q     <= 1'b0;
      halted_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          // The PC has been stable for this whole cycle, so rom_data is
          // settled. A fetch that has started always completes, whatever
          // en does.
          ir         <= rom_data;
          ir_addr_q  <= pc;
          pc         <= pc + AW'(1);
          ir_valid_q <= 1'b1;
          state      <= S_HOLD;
`ifdef FETCH_HALT_ON_WRAP_EN
          wrap_q     <= (pc == LAST_ADDR);
`endif
        end

        S_HOLD: begin
          // en is ignored until the held word has been accepted.
          if (ir_ready) begin
            ir_valid_q <= 1'b0;
`ifdef FETCH_HALT_ON_WRAP_EN
            if (wrap_q) begin
              // The PC has already wrapped to 0 and stays there in HALT.
              state    <= S_HALT;
              halted_q <= 1'b1;
              wrap_q   <= 1'b0;
            end else
`endif
            state <= en ? S_FETCH : S_IDLE;
          end
        end

`ifdef FETCH_HALT_ON_WRAP_EN
        S_HALT: begin
          // Parked. Only load (handled above) or reset leaves this state.
          state <= S_HALT;
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rom_addr = pc;
  assign ir_valid = ir_valid_q;
  assign instr    = ir[DW-1:DW/2];
  assign oprnd    = ir[DW/2-1:0];
  assign ir_addr  = ir_addr_q;

`ifdef FETCH_HALT_ON_WRAP_EN
  assign halted   = halted_q;
`else
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_rom_fetch_unit
//
// Directed bench for rom_fetch_unit. It contains a behavioural model of the
// program ROM with these words:
//   mem[0]     = A5
//   mem[1]     = 3C
//   mem[7F0]   = 91
//   mem[FFF]   = E2
//   all others = addr[7:0] ^ 5A   (so addr 2 -> 58, addr 3 -> 59)
//
// The wrap-around expectations follow FETCH_HALT_ON_WRAP_EN, so the bench
// must be compiled with the same macro setting as the design.
// ---------------------------------------------------------------------------
module tb_rom_fetch_unit;

  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk;
  logic            reset_n;
  logic            en;
  logic            load;
  logic [AW-1:0]   load_addr;
  logic [DW-1:0]   rom_data;
  logic [AW-1:0]   rom_addr;
  logic            ir_valid;
  logic            ir_ready;
  logic [DW/2-1:0] instr;
  logic [DW/2-1:0] oprnd;
  logic [AW-1:0]   ir_addr;
  logic            halted;

  int checks;
  int errors;

  rom_fetch_unit #(
    .AW       (AW),
    .DW       (DW),
    .RST_ADDR ('0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .load      (load),
    .load_addr (load_addr),
    .rom_data  (rom_data),
    .rom_addr  (rom_addr),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .instr     (instr),
    .oprnd     (oprnd),
    .ir_addr   (ir_addr),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    case (a)
      12'h000: rom_word = 8'hA5;
      12'h001: rom_word = 8'h3C;
      12'h7F0: rom_word = 8'h91;
      12'hFFF: rom_word = 8'hE2;
      default: rom_word = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  // Steps through falling edges until ir_valid is seen or max cycles pass.
  // n returns the number of falling edges waited. ok is 0 if the wait
  // timed out.
  task automatic wait_valid(input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (ir_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Applies reset for two cycles, then releases it on a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    load    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    int n;
    bit ok;
    en        = 1'b1;
    ir_ready  = 1'b1;
    load      = 1'b0;
    load_addr = '0;
    reset_n   = 1'b0;
    #2;
    checks++;
    if (rom_addr !== 12'h000 || ir_valid !== 1'b0 || instr !== 4'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rom_addr=%h ir_valid=%b instr=%h halted=%b, want 000 0 0 0",
               rom_addr, ir_valid, instr, halted);
    end
    // Reset is held across clock edges with en=1; nothing may move.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rom_addr !== 12'h000 || ir_valid !== 1'b0 || ir_addr !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold: rom_addr=%h ir_valid=%b ir_addr=%h, want 000 0 000",
               rom_addr, ir_valid, ir_addr);
    end
    reset_n = 1'b1;

    wait_valid(10, n, ok);
    checks++;
    if (!ok || instr !== 4'hA || oprnd !== 4'h5 || ir_addr !== 12'h000 || rom_addr !== 12'h001) begin
      errors++;
      $display("FAIL first_fetch: ok=%b instr=%h oprnd=%h ir_addr=%h rom_addr=%h, want 1 A 5 000 001",
               ok, instr, oprnd, ir_addr, rom_addr);
    end

    wait_valid(10, n, ok);
    checks++;
    if (!ok || instr !== 4'h3 || oprnd !== 4'hC || ir_addr !== 12'h001) begin
      errors++;
      $display("FAIL second_fetch: ok=%b instr=%h oprnd=%h ir_addr=%h, want 1 3 C 001",
               ok, instr, oprnd, ir_addr);
    end
    // With ready held high, a new instruction arrives every 2 cycles.
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL throughput: cycles=%0d, want 2", n);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stall_ready();
    int n;
    bit ok;
    bit bad;
    en       = 1'b1;
    ir_ready = 1'b0;
    do_reset();
    wait_valid(10, n, ok);
    checks++;
    if (!ok || instr !== 4'hA || oprnd !== 4'h5) begin
      errors++;
      $display("FAIL stall_first: ok=%b instr=%h oprnd=%h, want 1 A 5", ok, instr, oprnd);
    end
    // Five cycles with ready low: the held word and the PC must not change.
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ir_valid !== 1'b1 || instr !== 4'hA || rom_addr !== 12'h001 || ir_addr !== 12'h000)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_hold: ir_valid=%b instr=%h rom_addr=%h ir_addr=%h, want 1 A 001 000",
               ir_valid, instr, rom_addr, ir_addr);
    end
    ir_ready = 1'b1;
    wait_valid(10, n, ok);
    checks++;
    if (!ok || instr !== 4'h3 || oprnd !== 4'hC || ir_addr !== 12'h001) begin
      errors++;
      $display("FAIL stall_resume: ok=%b instr=%h oprnd=%h ir_addr=%h, want 1 3 C 001",
               ok, instr, oprnd, ir_addr);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_load();
    int n;
    bit ok;
    en       = 1'b1;
    ir_ready = 1'b0;
    do_reset();
    wait_valid(10, n, ok);
    // The unit is in HOLD with A5. Load and ready arrive together, so the
    // load must win and the held word must not be transferred.
    ir_ready  = 1'b1;
    load      = 1'b1;
    load_addr = 12'h7F0;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || rom_addr !== 12'h7F0) begin
      errors++;
      $display("FAIL load_drop: ir_valid=%b rom_addr=%h, want 0 7F0", ir_valid, rom_addr);
    end
    wait_valid(10, n, ok);
    checks++;
    if (!ok || instr !== 4'h9 || oprnd !== 4'h1 || ir_addr !== 12'h7F0 || n !== 1) begin
      errors++;
      $display("FAIL load_target: ok=%b instr=%h oprnd=%h ir_addr=%h cycles=%0d, want 1 9 1 7F0 1",
               ok, instr, oprnd, ir_addr, n);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wrap();
    int n;
    bit ok;
    en        = 1'b1;
    ir_ready  = 1'b1;
    @(negedge clk);
    load      = 1'b1;
    load_addr = 12'hFFF;
    @(negedge clk);
    load = 1'b0;
    wait_valid(10, n, ok);
    checks++;
    if (!ok || instr !== 4'hE || oprnd !== 4'h2 || ir_addr !== 12'hFFF || rom_addr !== 12'h000) begin
      errors++;
      $display("FAIL wrap_last: ok=%b instr=%h oprnd=%h ir_addr=%h rom_addr=%h, want 1 E 2 FFF 000",
               ok, instr, oprnd, ir_addr, rom_addr);
    end
`ifdef FETCH_HALT_ON_WRAP_EN
    begin
      bit bad;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (ir_valid !== 1'b0 || halted !== 1'b1 || rom_addr !== 12'h000)
          bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL wrap_halt: ir_valid=%b halted=%b rom_addr=%h, want 0 1 000",
                 ir_valid, halted, rom_addr);
      end
      load      = 1'b1;
      load_addr = 12'h000;
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (halted !== 1'b0) begin
        errors++;
        $display("FAIL halt_exit: halted=%b, want 0", halted);
      end
      wait_valid(10, n, ok);
      checks++;
      if (!ok || instr !== 4'hA || oprnd !== 4'h5 || ir_addr !== 12'h000) begin
        errors++;
        $display("FAIL halt_refetch: ok=%b instr=%h oprnd=%h ir_addr=%h, want 1 A 5 000",
                 ok, instr, oprnd, ir_addr);
      end
    end
`else
    wait_valid(10, n, ok);
    checks++;
    if (!ok || instr !== 4'hA || oprnd !== 4'h5 || ir_addr !== 12'h000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL wrap_zero: ok=%b instr=%h oprnd=%h ir_addr=%h halted=%b, want 1 A 5 000 0",
               ok, instr, oprnd, ir_addr, halted);
    end
`endif
  endtask

  // -------------------------------------------------------------------------
  task automatic test_en_stall();
    int n;
    bit ok;
    bit bad;
    en       = 1'b1;
    ir_ready = 1'b0;
    do_reset();
    wait_valid(10, n, ok);
    // Transfer with en=0: the unit must go idle with the PC frozen.
    en       = 1'b0;
    ir_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ir_valid !== 1'b0 || rom_addr !== 12'h001)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL en_idle: ir_valid=%b rom_addr=%h, want 0 001", ir_valid, rom_addr);
    end
    en = 1'b1;
    wait_valid(10, n, ok);
    checks++;
    if (!ok || instr !== 4'h3 || oprnd !== 4'hC || ir_addr !== 12'h001 || n !== 2) begin
      errors++;
      $display("FAIL en_resume: ok=%b instr=%h oprnd=%h ir_addr=%h cycles=%0d, want 1 3 C 001 2",
               ok, instr, oprnd, ir_addr, n);
    end
    // Ready is high, so the next edge moves the unit to FETCH. Drop en
    // during that FETCH cycle: the fetch must still complete.
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (ir_valid !== 1'b1 || instr !== 4'h5 || oprnd !== 4'h8 || ir_addr !== 12'h002) begin
      errors++;
      $display("FAIL en_drop_fetch: ir_valid=%b instr=%h oprnd=%h ir_addr=%h, want 1 5 8 002",
               ir_valid, instr, oprnd, ir_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ir_valid !== 1'b0 || rom_addr !== 12'h003) begin
      errors++;
      $display("FAIL en_drop_idle: ir_valid=%b rom_addr=%h, want 0 003", ir_valid, rom_addr);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_async_reset();
    int n;
    bit ok;
    en       = 1'b1;
    ir_ready = 1'b0;
    wait_valid(10, n, ok);
    checks++;
    if (!ok || instr !== 4'h5 || oprnd !== 4'h9 || ir_addr !== 12'h003) begin
      errors++;
      $display("FAIL pre_reset_hold: ok=%b instr=%h oprnd=%h ir_addr=%h, want 1 5 9 003",
               ok, instr, oprnd, ir_addr);
    end
    // Pulse reset between clock edges. The outputs must clear without
    // waiting for a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ir_valid !== 1'b0 || rom_addr !== 12'h000 || instr !== 4'h0 || oprnd !== 4'h0 ||
        ir_addr !== 12'h000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ir_valid=%b rom_addr=%h instr=%h oprnd=%h ir_addr=%h halted=%b, want 0 000 0 0 000 0",
               ir_valid, rom_addr, instr, oprnd, ir_addr, halted);
    end
    #1;
    reset_n = 1'b1;
    ir_ready = 1'b1;
    wait_valid(10, n, ok);
    checks++;
    if (!ok || instr !== 4'hA || oprnd !== 4'h5 || ir_addr !== 12'h000) begin
      errors++;
      $display("FAIL post_reset_fetch: ok=%b instr=%h oprnd=%h ir_addr=%h, want 1 A 5 000",
               ok, instr, oprnd, ir_addr);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stall_ready();
    test_load();
    test_wrap();
    test_en_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
